// File: rtl/dram_ctrl.sv
// dram_ctrl: turns single-word read/write requests into PRECHARGE/ACTIVATE/
// READ/WRITE pin sequences. The last activated row is kept open, so a request
// to that row goes straight to the column command.
//
// Request handshake: a request transfers on a clock edge where req_valid and
// req_ready are both high. req_ready is high only while the controller is idle.
// All request fields are captured on that edge and the inputs are ignored until
// the controller is idle again. Completion is a one-cycle resp_valid pulse.
module dram_ctrl #(
    parameter int T_RP  = 5,
    parameter int T_RCD = 5,
    parameter int T_WR  = 5,
    parameter int T_TO  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        DRAM_CSn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [3:0]  DRAM_WEn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic [31:0] DRAM_Q,
    input  logic        DRAM_valid,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PRE      = 4'd1,
        PRE_WAIT = 4'd2,
        ACT      = 4'd3,
        ACT_WAIT = 4'd4,
        CMD      = 4'd5,
        RWAIT    = 4'd6,
        WWAIT    = 4'd7,
        DONE     = 4'd8
    } state_t;

    // A wait state is left when the counter reaches its last value, giving
    // exactly T_x idle-pin cycles between commands.
    localparam logic [7:0] RP_LAST  = 8'(T_RP - 1);
    localparam logic [7:0] RCD_LAST = 8'(T_RCD - 1);
    localparam logic [7:0] WR_LAST  = 8'(T_WR - 1);
    localparam logic [7:0] TO_LAST  = 8'(T_TO - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt;
    logic        ready_en;
    logic        row_open;
    logic [10:0] open_row;

    logic        lat_write;
    logic [10:0] lat_row;
    logic [9:0]  lat_col;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_wdata;

    logic        accept;
    logic        hit;
    logic        cur_write;
    logic [10:0] cur_row;
    logic [9:0]  cur_col;
    logic [3:0]  cur_wstrb;
    logic [31:0] cur_wdata;

    logic        csn_nx;
    logic        rasn_nx;
    logic        casn_nx;
    logic [3:0]  wen_nx;
    logic [10:0] a_nx;
    logic [31:0] d_nx;

    // ready_en keeps req_ready low from reset until the first clock edge.
    assign req_ready  = ready_en && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign hit        = row_open && (req_addr[22:12] == open_row);
    assign resp_valid = (state == DONE);
    assign dbg_state  = state;

    // The command registered on the accept edge must see the live request;
    // later commands use the captured copy.
    assign cur_write = accept ? req_write       : lat_write;
    assign cur_row   = accept ? req_addr[22:12] : lat_row;
    assign cur_col   = accept ? req_addr[11:2]  : lat_col;
    assign cur_wstrb = accept ? req_wstrb       : lat_wstrb;
    assign cur_wdata = accept ? req_wdata       : lat_wdata;

    // Next-state logic: command states last one cycle, wait states count.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept) next_state = hit ? CMD : (row_open ? PRE : ACT);
            PRE:      next_state = PRE_WAIT;
            PRE_WAIT: if (cnt == RP_LAST) next_state = ACT;
            ACT:      next_state = ACT_WAIT;
            ACT_WAIT: if (cnt == RCD_LAST) next_state = CMD;
            CMD:      next_state = lat_write ? WWAIT : RWAIT;
            RWAIT:    if (DRAM_valid || (cnt == TO_LAST)) next_state = DONE;
            WWAIT:    if (cnt == WR_LAST) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Pin values for the cycle about to start, decoded from the next state.
    always_comb begin
        csn_nx  = 1'b1;
        rasn_nx = 1'b1;
        casn_nx = 1'b1;
        wen_nx  = 4'hF;
        a_nx    = '0;
        d_nx    = '0;
        case (next_state)
            PRE: begin
                csn_nx  = 1'b0;
                rasn_nx = 1'b0;
                wen_nx  = 4'h0;
            end
            ACT: begin
                csn_nx  = 1'b0;
                rasn_nx = 1'b0;
                a_nx    = cur_row;
            end
            CMD: begin
                csn_nx  = 1'b0;
                casn_nx = 1'b0;
                a_nx    = {1'b0, cur_col};
                if (cur_write) begin
                    wen_nx = ~cur_wstrb;
                    d_nx   = cur_wdata;
                end
            end
            default: ;
        endcase
    end

    // State register and wait counter (cleared on every state change).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= next_state;
            ready_en <= 1'b1;
            if (next_state != state)
                cnt <= '0;
            else if ((state == PRE_WAIT) || (state == ACT_WAIT) ||
                     (state == RWAIT) || (state == WWAIT))
                cnt <= cnt + 8'd1;
        end
    end

    // Request capture and open-row tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_write <= 1'b0;
            lat_row   <= '0;
            lat_col   <= '0;
            lat_wstrb <= '0;
            lat_wdata <= '0;
            row_open  <= 1'b0;
            open_row  <= '0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_row   <= req_addr[22:12];
                lat_col   <= req_addr[11:2];
                lat_wstrb <= req_wstrb;
                lat_wdata <= req_wdata;
            end
            if (next_state == ACT) begin
                row_open <= 1'b1;
                open_row <= cur_row;
            end
        end
    end

    // Response data and timeout flag; rdata holds until the next good read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if ((state == RWAIT) && DRAM_valid)
                resp_rdata <= DRAM_Q;
            if ((next_state == DONE) && (state != DONE))
                resp_err <= (state == RWAIT) && !DRAM_valid;
        end
    end

    // Registered DRAM pins; reset forces them idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DRAM_CSn  <= 1'b1;
            DRAM_RASn <= 1'b1;
            DRAM_CASn <= 1'b1;
            DRAM_WEn  <= 4'hF;
            DRAM_A    <= '0;
            DRAM_D    <= '0;
        end else begin
            DRAM_CSn  <= csn_nx;
            DRAM_RASn <= rasn_nx;
            DRAM_CASn <= casn_nx;
            DRAM_WEn  <= wen_nx;
            DRAM_A    <= a_nx;
            DRAM_D    <= d_nx;
        end
    end

endmodule
